display_compositor: RTL and testbench

- Final stage before the 16x16 bi-colour LED matrix.
- Takes the live game planes (asteroids, player) and the end-sequence frame, and selects between them by game mode.
- Snapshots the chosen image once per frame so the display never tears mid-scan.
- Row-scans the image onto the matrix with a programmable dwell time and anti-ghosting blanking.

---
 rtl/display_compositor.sv | 148 ++++++++++++++
 tb/tb_display_compositor.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/display_compositor.sv
// display_compositor: selects game planes or end frame by mode, snapshots the
// chosen image once per frame and row-scans it onto a 16x16 bi-colour matrix.
// Optional macro BLINK_EN: blink the end image every BLINK_FRAMES frames.
module display_compositor #(
  parameter int unsigned DWELL = 8,
  parameter int unsigned BLANK = 1
`ifdef BLINK_EN
  ,
  parameter int unsigned BLINK_FRAMES = 16
`endif
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ENDen,
  input  logic [15:0][15:0] PixGAME,
  input  logic [15:0][15:0] PixPLAYER,
  input  logic [15:0][15:0] PixEND,
  output logic [15:0]       RowEn,
  output logic [15:0]       RedRow,
  output logic [15:0]       GrnRow,
  output logic              FrameStart
);

  localparam int unsigned CW = (DWELL <= 2) ? 1 : $clog2(DWELL);

  // run_q is low only until the first edge after reset, which is itself a frame boundary
  logic              run_q, run_d;
  logic [CW-1:0]     c_q, c_d;
  logic [3:0]        row_q, row_d;
  logic              mode_q, mode_d;
  logic [15:0][15:0] redbuf_q, redbuf_d;
  logic [15:0][15:0] grnbuf_q, grnbuf_d;
  logic [15:0]       row_en_q, row_en_d;
  logic [15:0]       red_row_q, red_row_d;
  logic [15:0]       grn_row_q, grn_row_d;
  logic              frame_start_q, frame_start_d;
  logic              boundary;
  logic              show;

`ifdef BLINK_EN
  localparam int unsigned FW = (BLINK_FRAMES <= 1) ? 1 : $clog2(2 * BLINK_FRAMES);
  logic [FW-1:0] f_q, f_d;
`endif

  // Scan counters, frame snapshot and output decode for the state after this edge
  always_comb begin
    run_d         = 1'b1;
    c_d           = c_q;
    row_d         = row_q;
    mode_d        = mode_q;
    redbuf_d      = redbuf_q;
    grnbuf_d      = grnbuf_q;
    boundary      = 1'b0;
    show          = 1'b1;
    row_en_d      = '0;
    red_row_d     = '0;
    grn_row_d     = '0;
`ifdef BLINK_EN
    f_d           = f_q;
`endif

    if (!run_q) begin
      boundary = 1'b1;
    end else if (c_q == CW'(DWELL - 1)) begin
      c_d      = '0;
      row_d    = row_q + 4'd1;
      boundary = (row_q == 4'd15);
    end else begin
      c_d = c_q + CW'(1);
    end

    if (boundary) begin
      mode_d = ENDen;
      if (ENDen) begin
        redbuf_d = PixEND;
        grnbuf_d = '0;
      end else begin
        redbuf_d = PixGAME;
        grnbuf_d = PixPLAYER;
      end
`ifdef BLINK_EN
      // f counts frames since entry to end mode; zero whenever either side is game mode
      if (mode_q && ENDen) begin
        f_d = (f_q == FW'(2 * BLINK_FRAMES - 1)) ? '0 : f_q + FW'(1);
      end else begin
        f_d = '0;
      end
`endif
    end

`ifdef BLINK_EN
    show = !(mode_d && (f_d >= FW'(BLINK_FRAMES)));
`endif

    frame_start_d = boundary;
    if (c_d >= CW'(BLANK)) begin
      row_en_d = 16'd1 << row_d;
      if (show) begin
        red_row_d = redbuf_d[row_d];
        grn_row_d = grnbuf_d[row_d];
      end
    end
  end

  // State and output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      run_q         <= 1'b0;
      c_q           <= '0;
      row_q         <= '0;
      mode_q        <= 1'b0;
      redbuf_q      <= '0;
      grnbuf_q      <= '0;
      row_en_q      <= '0;
      red_row_q     <= '0;
      grn_row_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      run_q         <= run_d;
      c_q           <= c_d;
      row_q         <= row_d;
      mode_q        <= mode_d;
      redbuf_q      <= redbuf_d;
      grnbuf_q      <= grnbuf_d;
      row_en_q      <= row_en_d;
      red_row_q     <= red_row_d;
      grn_row_q     <= grn_row_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef BLINK_EN
  // Blink frame counter
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      f_q <= '0;
    end else begin
      f_q <= f_d;
    end
  end
`endif

  assign RowEn      = row_en_q;
  assign RedRow     = red_row_q;
  assign GrnRow     = grn_row_q;
  assign FrameStart = frame_start_q;

endmodule

// File: tb/tb_display_compositor.sv
// Randomized bench for display_compositor against a frame/position reference model.
module tb_display_compositor;

  localparam int unsigned DW = 4;
  localparam int unsigned BL = 1;
  localparam int unsigned FP = 16 * DW;
`ifdef BLINK_EN
  localparam int unsigned BF = 2;
`endif

  logic              CLK = 1'b0;
  logic              RST = 1'b0;
  logic              ENDen = 1'b0;
  logic [15:0][15:0] PixGAME;
  logic [15:0][15:0] PixPLAYER;
  logic [15:0][15:0] PixEND;
  logic [15:0]       RowEn;
  logic [15:0]       RedRow;
  logic [15:0]       GrnRow;
  logic              FrameStart;

  always #5 CLK = ~CLK;

  display_compositor #(
    .DWELL(DW),
    .BLANK(BL)
`ifdef BLINK_EN
    ,
    .BLINK_FRAMES(BF)
`endif
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .ENDen     (ENDen),
    .PixGAME   (PixGAME),
    .PixPLAYER (PixPLAYER),
    .PixEND    (PixEND),
    .RowEn     (RowEn),
    .RedRow    (RedRow),
    .GrnRow    (GrnRow),
    .FrameStart(FrameStart)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: k = edges since reset release minus one; snapshot per frame
  int          k;
  logic [15:0] m_red [16];
  logic [15:0] m_grn [16];
  logic        m_mode;
  int          m_endf;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  task automatic model_reset();
    k      = -1;
    m_mode = 1'b0;
    m_endf = 0;
    for (int r = 0; r < 16; r++) begin
      m_red[r] = '0;
      m_grn[r] = '0;
    end
  endtask

  task automatic model_edge();
    k++;
    if (k % FP == 0) begin
      m_endf = (m_mode && ENDen) ? m_endf + 1 : 0;
      m_mode = ENDen;
      for (int r = 0; r < 16; r++) begin
        m_red[r] = ENDen ? PixEND[r] : PixGAME[r];
        m_grn[r] = ENDen ? 16'h0000 : PixPLAYER[r];
      end
    end
  endtask

  task automatic compare();
    int          pos, row, c;
    logic        show;
    logic [15:0] e_row, e_red, e_grn;
    pos  = k % FP;
    row  = pos / DW;
    c    = pos % DW;
    show = 1'b1;
`ifdef BLINK_EN
    if (m_mode && ((m_endf / BF) % 2 == 1)) show = 1'b0;
`endif
    e_row = (c >= BL) ? (16'h0001 << row) : 16'h0000;
    e_red = (c >= BL && show) ? m_red[row] : 16'h0000;
    e_grn = (c >= BL && show) ? m_grn[row] : 16'h0000;
    chk("rowen", RowEn, e_row);
    chk("red", RedRow, e_red);
    chk("grn", GrnRow, e_grn);
    chk("fstart", 16'(FrameStart), 16'(pos == 0));
  endtask

  task automatic cycle();
    @(posedge CLK);
    if (RST) model_edge();
    @(negedge CLK);
    compare();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rowen"}, RowEn, 16'h0000);
    chk({tag, "_red"}, RedRow, 16'h0000);
    chk({tag, "_grn"}, GrnRow, 16'h0000);
    chk({tag, "_fs"}, 16'(FrameStart), 16'h0000);
  endtask

  task automatic rand_planes();
    for (int r = 0; r < 16; r++) begin
      PixGAME[r]   = 16'($urandom);
      PixPLAYER[r] = 16'($urandom);
      PixEND[r]    = 16'($urandom);
    end
  endtask

  initial begin
    bit found;
    model_reset();
    rand_planes();
    PixGAME[0]   = 16'h8001;
    PixPLAYER[0] = 16'h0001;
    ENDen        = 1'b0;
    repeat (3) @(negedge CLK);
    check_zero("reset");

    // Release and walk the first frames with the directed mid-frame events
    RST = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (i == 10) PixGAME[5] = ~PixGAME[5];
      if (i == 30) begin
        ENDen = 1'b1;
        for (int r = 0; r < 16; r++) PixEND[r] = 16'($urandom);
      end
      if (i == 70) ENDen = 1'b0;
      if (i == 100) rand_planes();
    end

    // Random mode toggles and pixel churn
    for (int i = 0; i < 512; i++) begin
      cycle();
      if ($urandom_range(0, 15) == 0) ENDen = 1'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        PixGAME[$urandom_range(0, 15)]   = 16'($urandom);
        PixPLAYER[$urandom_range(0, 15)] = 16'($urandom);
        PixEND[$urandom_range(0, 15)]    = 16'($urandom);
      end
    end

    // Async reset while row 7 is lit
    found = 1'b0;
    for (int i = 0; i < 2 * FP && !found; i++) begin
      cycle();
      if (k % FP == 7 * DW + 2) found = 1'b1;
    end
    chk("row7_found", 16'(found), 16'h0001);
    #2 RST = 1'b0;
    #1 check_zero("async");
    model_reset();
    @(negedge CLK);
    check_zero("held");
    ENDen = 1'b1;
    RST   = 1'b1;

    // End mode held across several frames
    for (int i = 0; i < 6 * FP; i++) begin
      cycle();
      if (i == 3 * FP + 5) PixEND[$urandom_range(0, 15)] = 16'($urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
